// File: rtl/store_cmd_scheduler.sv
// Queues STORE commands in a small FIFO and issues them one at a time to the
// store execution unit. Zero-length commands are dropped without being issued.
module store_cmd_scheduler #(
    parameter int ADDR_WIDTH = 24,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4:0]              cmd_buf_id,
    input  logic [9:0]              cmd_length,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    output logic                    exec_start,
    output logic [4:0]              exec_buf_id,
    output logic [9:0]              exec_length,
    output logic [ADDR_WIDTH-1:0]   exec_addr,
    input  logic                    exec_done,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    cmpl_pulse,
    output logic                    drop_pulse
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0]            buf_id;
        logic [9:0]            length;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_pending;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_exec_start;
    logic               r_cmpl;
    logic               r_drop;
    entry_t             r_exec;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_drop;
    logic               w_cmpl;
    entry_t             w_head;
    entry_t             w_in;

    assign w_ready = (r_pending < FULL_CNT);
    assign w_push  = cmd_valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_in    = '{buf_id: cmd_buf_id, length: cmd_length, addr: cmd_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pop happens in the IDLE cycle itself; the issued command appears one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_cmpl      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending != '0) begin
                    w_pop = 1'b1;
                    if (w_head.length != '0) begin
                        w_issue     = 1'b1;
                        w_state_nxt = WAIT;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (exec_done) begin
                    w_cmpl      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Storage is not reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pending    <= '0;
            r_exec_start <= 1'b0;
            r_cmpl       <= 1'b0;
            r_drop       <= 1'b0;
            r_exec       <= '0;
        end else begin
            r_exec_start <= w_issue;
            r_cmpl       <= w_cmpl;
            r_drop       <= w_drop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_pending <= r_pending + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_pending <= r_pending - CNT_W'(1);
            end
            if (w_issue) begin
                r_exec <= w_head;
            end
        end
    end

    assign cmd_ready   = w_ready;
    assign exec_start  = r_exec_start;
    assign exec_buf_id = r_exec.buf_id;
    assign exec_length = r_exec.length;
    assign exec_addr   = r_exec.addr;
    assign busy        = (r_state == WAIT);
    assign pending     = r_pending;
    assign cmpl_pulse  = r_cmpl;
    assign drop_pulse  = r_drop;

endmodule
